// File: rtl/pong_pkg.sv
// Shared types and widths for the pong game controller and its datapath.
package pong_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SERVE,
    PLAY,
    MISS,
    OVER
  } game_state_t;

  localparam int SCORE_W = 8;
  localparam int SPEED_W = 2;

  // Two-digit BCD increment that sticks at 99.
  function automatic logic [SCORE_W-1:0] bcd_inc(input logic [SCORE_W-1:0] s);
    logic [SCORE_W-1:0] r;
    if (s == 8'h99)
      r = s;
    else if (s[3:0] == 4'd9)
      r = {s[7:4] + 4'd1, 4'd0};
    else
      r = {s[7:4], s[3:0] + 4'd1};
    return r;
  endfunction

endpackage

// File: rtl/pong_btn_sync.sv
// Start button synchronizer with a registered rising-edge detector.
module pong_btn_sync (
  input  logic clk25,
  input  logic rst,
  input  logic btn_in,
  output logic press_pulse
);

  logic       sync0;
  logic       sync1;
  logic       sync1_d;
  logic       armed;
  logic [1:0] fill;

  // armed stays low until the pipeline holds real samples and has seen the
  // button released, so a press held through reset never produces an edge.
  always_ff @(posedge clk25) begin
    if (rst) begin
      sync0       <= 1'b0;
      sync1       <= 1'b0;
      sync1_d     <= 1'b0;
      armed       <= 1'b0;
      fill        <= 2'd0;
      press_pulse <= 1'b0;
    end else begin
      sync0   <= btn_in;
      sync1   <= sync0;
      sync1_d <= sync1;
      if (fill != 2'd2)
        fill <= fill + 2'd1;
      if (fill == 2'd2 && !sync1)
        armed <= 1'b1;
      press_pulse <= armed & sync1 & ~sync1_d;
    end
  end

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencing: serve, play, miss and game-over, with BCD score,
// lives and ball speed.
module pong_game_ctrl #(
  parameter int unsigned NUM_LIVES      = 3,
  parameter int unsigned SERVE_FRAMES   = 60,
  parameter int unsigned MISS_FRAMES    = 63,
  parameter int unsigned HITS_PER_LEVEL = 4
) (
  input  logic       clk25,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       start_btn,
  input  logic       paddle_hit,
  input  logic       ball_miss,
  output logic       ball_load,
  output logic       ball_run,
  output logic [2:0] ball_step,
  output logic       miss_flash,
  output logic [7:0] score,
  output logic [1:0] lives,
  output logic       game_over
);

  import pong_pkg::*;

  game_state_t        state;
  logic               start_evt;
  logic [7:0]         frame_cnt;
  logic [3:0]         hit_cnt;
  logic [SPEED_W-1:0] speed_level;

  pong_btn_sync u_btn_sync (
    .clk25       (clk25),
    .rst         (rst),
    .btn_in      (start_btn),
    .press_pulse (start_evt)
  );

  always_ff @(posedge clk25) begin
    if (rst) begin
      state       <= IDLE;
      score       <= 8'h00;
      lives       <= 2'(NUM_LIVES);
      speed_level <= '0;
      hit_cnt     <= 4'd0;
      frame_cnt   <= 8'd0;
      ball_load   <= 1'b0;
      ball_run    <= 1'b0;
      ball_step   <= 3'd2;
      miss_flash  <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      ball_load <= 1'b0;
      case (state)
        IDLE, OVER: begin
          if (start_evt) begin
            state       <= SERVE;
            score       <= 8'h00;
            lives       <= 2'(NUM_LIVES);
            speed_level <= '0;
            hit_cnt     <= 4'd0;
            frame_cnt   <= 8'd0;
            ball_load   <= 1'b1;
            ball_run    <= 1'b0;
            ball_step   <= 3'd2;
            miss_flash  <= 1'b0;
            game_over   <= 1'b0;
          end
        end
        SERVE: begin
          if (frame_tick) begin
            if (frame_cnt == 8'(SERVE_FRAMES - 1)) begin
              state     <= PLAY;
              frame_cnt <= 8'd0;
              ball_run  <= 1'b1;
            end else begin
              frame_cnt <= frame_cnt + 8'd1;
            end
          end
        end
        // A miss in the same cycle as a hit discards the hit entirely.
        PLAY: begin
          if (ball_miss) begin
            state      <= MISS;
            lives      <= lives - 2'd1;
            miss_flash <= 1'b1;
            ball_run   <= 1'b0;
            frame_cnt  <= 8'd0;
          end else if (paddle_hit) begin
            score <= bcd_inc(score);
            if (hit_cnt == 4'(HITS_PER_LEVEL - 1)) begin
              hit_cnt <= 4'd0;
              if (speed_level != {SPEED_W{1'b1}}) begin
                speed_level <= speed_level + SPEED_W'(1);
                ball_step   <= 3'(speed_level) + 3'd3;
              end
            end else begin
              hit_cnt <= hit_cnt + 4'd1;
            end
          end
        end
        MISS: begin
          if (frame_tick) begin
            if (frame_cnt == 8'(MISS_FRAMES - 1)) begin
              frame_cnt  <= 8'd0;
              miss_flash <= 1'b0;
              if (lives == 2'd0) begin
                state     <= OVER;
                game_over <= 1'b1;
              end else begin
                state       <= SERVE;
                speed_level <= '0;
                ball_step   <= 3'd2;
                ball_load   <= 1'b1;
              end
            end else begin
              frame_cnt <= frame_cnt + 8'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Scoreboard bench for pong_game_ctrl: expectations are queued as stimulus
// is applied and compared against the registered outputs a cycle later.
module tb_pong_game_ctrl;

  localparam int S_LOAD  = 0;
  localparam int S_RUN   = 1;
  localparam int S_STEP  = 2;
  localparam int S_FLASH = 3;
  localparam int S_SCORE = 4;
  localparam int S_LIVES = 5;
  localparam int S_OVER  = 6;

  logic       clk25 = 1'b0;
  logic       rst;
  logic       frame_tick;
  logic       start_btn;
  logic       paddle_hit;
  logic       ball_miss;
  logic       ball_load;
  logic       ball_run;
  logic [2:0] ball_step;
  logic       miss_flash;
  logic [7:0] score;
  logic [1:0] lives;
  logic       game_over;

  int checks   = 0;
  int failures = 0;

  string       tagQ[$];
  int          sigQ[$];
  logic [31:0] expQ[$];

  int tbHits;
  int tbHitCnt;
  int tbSpeed;
  int tbLives;

  always #20 clk25 = ~clk25;

  pong_game_ctrl #(
    .NUM_LIVES      (3),
    .SERVE_FRAMES   (60),
    .MISS_FRAMES    (63),
    .HITS_PER_LEVEL (4)
  ) dut (
    .clk25      (clk25),
    .rst        (rst),
    .frame_tick (frame_tick),
    .start_btn  (start_btn),
    .paddle_hit (paddle_hit),
    .ball_miss  (ball_miss),
    .ball_load  (ball_load),
    .ball_run   (ball_run),
    .ball_step  (ball_step),
    .miss_flash (miss_flash),
    .score      (score),
    .lives      (lives),
    .game_over  (game_over)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [31:0] observe(input int sig);
    logic [31:0] v;
    case (sig)
      S_LOAD:  v = {31'd0, ball_load};
      S_RUN:   v = {31'd0, ball_run};
      S_STEP:  v = {29'd0, ball_step};
      S_FLASH: v = {31'd0, miss_flash};
      S_SCORE: v = {24'd0, score};
      S_LIVES: v = {30'd0, lives};
      default: v = {31'd0, game_over};
    endcase
    return v;
  endfunction

  task automatic expectOut(input string tag, input int sig, input logic [31:0] value);
    tagQ.push_back(tag);
    sigQ.push_back(sig);
    expQ.push_back(value);
  endtask

  task automatic drainScoreboard();
    string       t;
    int          s;
    logic [31:0] e;
    while (tagQ.size() > 0) begin
      t = tagQ.pop_front();
      s = sigQ.pop_front();
      e = expQ.pop_front();
      checkOutput(t, observe(s), e);
    end
  endtask

  function automatic logic [31:0] bcdOf(input int h);
    int c;
    c = (h > 99) ? 99 : h;
    return 32'(((c / 10) << 4) | (c % 10));
  endfunction

  task automatic stepCycles(input int n);
    repeat (n) begin
      @(posedge clk25);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic tick, input logic hit, input logic miss);
    frame_tick = tick;
    paddle_hit = hit;
    ball_miss  = miss;
    stepCycles(1);
    frame_tick = 1'b0;
    paddle_hit = 1'b0;
    ball_miss  = 1'b0;
  endtask

  task automatic sendTicks(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0);
  endtask

  task automatic sendHits(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      tbHits++;
      tbHitCnt++;
      if (tbHitCnt == 4) begin
        tbHitCnt = 0;
        if (tbSpeed < 3) tbSpeed++;
      end
    end
  endtask

  task automatic expectResetValues(input string tag);
    expectOut({tag, "_load"},  S_LOAD,  0);
    expectOut({tag, "_run"},   S_RUN,   0);
    expectOut({tag, "_step"},  S_STEP,  2);
    expectOut({tag, "_flash"}, S_FLASH, 0);
    expectOut({tag, "_score"}, S_SCORE, 0);
    expectOut({tag, "_lives"}, S_LIVES, 3);
    expectOut({tag, "_over"},  S_OVER,  0);
    drainScoreboard();
  endtask

  task automatic pressStart();
    start_btn = 1'b1;
    stepCycles(3);
    expectOut("start_load_early", S_LOAD, 0);
    drainScoreboard();
    stepCycles(1);
    tbHits = 0; tbHitCnt = 0; tbSpeed = 0; tbLives = 3;
    expectOut("start_load",  S_LOAD,  1);
    expectOut("start_score", S_SCORE, bcdOf(tbHits));
    expectOut("start_lives", S_LIVES, 32'(tbLives));
    expectOut("start_over",  S_OVER,  0);
    expectOut("start_step",  S_STEP,  2);
    drainScoreboard();
    start_btn = 1'b0;
    stepCycles(1);
    expectOut("start_load_single", S_LOAD, 0);
    drainScoreboard();
  endtask

  task automatic serveToPlay();
    sendTicks(59);
    expectOut("serve_run_before", S_RUN, 0);
    drainScoreboard();
    sendTicks(1);
    expectOut("serve_run_after", S_RUN,  1);
    expectOut("serve_load",      S_LOAD, 0);
    drainScoreboard();
  endtask

  initial begin
    rst = 1'b1; frame_tick = 1'b0; start_btn = 1'b0; paddle_hit = 1'b0; ball_miss = 1'b0;
    tbHits = 0; tbHitCnt = 0; tbSpeed = 0; tbLives = 3;
    stepCycles(3);
    rst = 1'b0;
    stepCycles(5);
    expectResetValues("reset");

    pressStart();
    applyStimulus(1'b0, 1'b1, 1'b0);
    expectOut("serve_hit_ignored", S_SCORE, 0);
    drainScoreboard();
    serveToPlay();

    sendHits(5);
    expectOut("hits5_score", S_SCORE, bcdOf(tbHits));
    expectOut("hits5_step",  S_STEP,  32'(2 + tbSpeed));
    drainScoreboard();

    applyStimulus(1'b0, 1'b1, 1'b1);
    tbLives--;
    expectOut("coincide_score", S_SCORE, bcdOf(tbHits));
    expectOut("coincide_lives", S_LIVES, 32'(tbLives));
    expectOut("coincide_flash", S_FLASH, 1);
    expectOut("coincide_run",   S_RUN,   0);
    drainScoreboard();
    sendTicks(62);
    expectOut("miss_flash_hold", S_FLASH, 1);
    drainScoreboard();
    sendTicks(1);
    tbSpeed = 0;
    expectOut("miss_reload",    S_LOAD,  1);
    expectOut("miss_step",      S_STEP,  32'(2 + tbSpeed));
    expectOut("miss_flash_end", S_FLASH, 0);
    drainScoreboard();
    applyStimulus(1'b0, 1'b0, 1'b0);
    expectOut("miss_load_single", S_LOAD, 0);
    drainScoreboard();
    serveToPlay();

    sendHits(13);
    expectOut("hits13_score", S_SCORE, bcdOf(tbHits));
    expectOut("hits13_step",  S_STEP,  32'(2 + tbSpeed));
    drainScoreboard();
    sendHits(4);
    expectOut("speed_sat_step", S_STEP, 32'(2 + tbSpeed));
    drainScoreboard();
    sendHits(99 - tbHits);
    expectOut("score_99", S_SCORE, bcdOf(tbHits));
    drainScoreboard();
    sendHits(1);
    expectOut("score_sat", S_SCORE, bcdOf(tbHits));
    drainScoreboard();

    applyStimulus(1'b0, 1'b0, 1'b1);
    tbLives--;
    expectOut("miss2_lives", S_LIVES, 32'(tbLives));
    drainScoreboard();
    sendTicks(63);
    serveToPlay();
    applyStimulus(1'b0, 1'b0, 1'b1);
    tbLives--;
    sendTicks(63);
    expectOut("over_flag",  S_OVER,  1);
    expectOut("over_load",  S_LOAD,  0);
    expectOut("over_lives", S_LIVES, 32'(tbLives));
    expectOut("over_score", S_SCORE, bcdOf(tbHits));
    expectOut("over_flash", S_FLASH, 0);
    drainScoreboard();
    applyStimulus(1'b1, 1'b1, 1'b0);
    expectOut("over_hit_ignored", S_SCORE, bcdOf(tbHits));
    drainScoreboard();

    pressStart();
    serveToPlay();
    applyStimulus(1'b0, 1'b0, 1'b1);
    expectOut("miss3_flash", S_FLASH, 1);
    drainScoreboard();

    start_btn = 1'b1;
    stepCycles(4);
    expectOut("miss_start_ignored", S_LOAD, 0);
    drainScoreboard();
    rst = 1'b1;
    stepCycles(2);
    rst = 1'b0;
    stepCycles(1);
    expectResetValues("midreset");
    for (int i = 0; i < 12; i++) begin
      stepCycles(1);
      expectOut("held_btn_no_start", S_LOAD, 0);
      drainScoreboard();
    end
    start_btn = 1'b0;
    stepCycles(5);
    pressStart();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pong_game_ctrl.md
PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

Interface
REQ-001 Parameter NUM_LIVES, 3, balls per game, range 1..3.
REQ-002 Parameter SERVE_FRAMES, 60, frame ticks the ball is held before launch, range 1..255.
REQ-003 Parameter MISS_FRAMES, 63, frame ticks of miss flash, range 1..255.
REQ-004 Parameter HITS_PER_LEVEL, 4, paddle hits per speed increase, range 1..15.
REQ-005 clk25  input  1  pixel clock; sole clock domain.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 frame_tick  input  1  one-cycle pulse at end of visible frame (x=0, y=480).
REQ-008 start_btn  input  1  raw asynchronous push-button, active-high.
REQ-009 paddle_hit  input  1  one-cycle pulse: ball bounced off paddle.
REQ-010 ball_miss  input  1  one-cycle pulse: ball touched bottom edge.
REQ-011 ball_load  output  1  one-cycle pulse: datapath reloads ball to serve position and direction.
REQ-012 ball_run  output  1  high: datapath advances ball on frame_tick.
REQ-013 ball_step  output  3  pixels per frame = 2 + speed_level.
REQ-014 miss_flash  output  1  high while in MISS.
REQ-015 score  output  8  two BCD digits, [7:4] tens, [3:0] units.
REQ-016 lives  output  2  remaining balls.
REQ-017 game_over  output  1  high while in OVER.

Function
REQ-018 FSM states IDLE, SERVE, PLAY, MISS, OVER; all outputs registered; each output changes one cycle after the causing input.
REQ-019 start_btn is passed through a 2-flop synchronizer, then rising-edge detected to give start_evt; press-to-start_evt latency is 3 cycles.
REQ-020 IDLE: on start_evt, go to SERVE; clear score, speed_level and hit count; set lives=NUM_LIVES; pulse ball_load.
REQ-021 SERVE: ball_run=0; count frame_ticks; on tick with count==SERVE_FRAMES-1, go to PLAY; clear count.
REQ-022 PLAY: ball_run=1; on paddle_hit, increment score BCD, with units 9 wrapping to 0 and carrying into tens.
REQ-023 Score saturates at 0x99; hits still advance the speed logic at saturation.
REQ-024 PLAY: on paddle_hit, increment hit count; on reaching HITS_PER_LEVEL, clear it and increment speed_level (2 bits), saturating at 3.
REQ-025 PLAY: on ball_miss, decrement lives, go to MISS, and set miss_flash.
REQ-026 If paddle_hit and ball_miss coincide, the miss wins: no score change.
REQ-027 MISS: ball_run=0; count MISS_FRAMES ticks.
REQ-028 MISS timeout: if lives==0, go to OVER; otherwise reset speed_level to 0, go to SERVE and pulse ball_load.
REQ-029 OVER: score and lives held; on start_evt, behave as IDLE start (REQ-020).
REQ-030 start_evt is ignored in SERVE, PLAY and MISS.
REQ-031 paddle_hit and ball_miss are ignored outside PLAY.
REQ-032 frame_tick is ignored in IDLE, PLAY and OVER.
REQ-033 ball_load is never asserted for two consecutive cycles.

Reset
REQ-034 rst has priority over all inputs, including when rst is asserted mid-state.
REQ-035 Reset values: state IDLE; score 0x00; lives NUM_LIVES; speed_level, hit count and frame count 0; synchronizer flops 0.
REQ-036 Reset values of outputs: ball_load, ball_run, miss_flash and game_over 0; ball_step 2.
REQ-037 A button held through the rst release produces no start_evt until it is released and pressed again.

Structure
REQ-038 Shared package pong_pkg holds the state enumeration, the BCD score width and the speed_level width, for reuse by the game datapath.
REQ-039 The synchronizer and edge detector form sub-module pong_btn_sync (clk25, rst, btn_in, press_pulse); all else is in pong_game_ctrl.

Verification
REQ-040 Reset, press start, SERVE_FRAMES=60 -> ball_load pulse 4 cycles after press; ball_run rises on the cycle after the 60th frame_tick.
REQ-041 In PLAY, 13 paddle_hits -> score 0x13, speed_level 3, ball_step 5; a further 4 hits -> ball_step stays 5.
REQ-042 Start a game with score 0x99, send paddle_hit -> score stays 0x99.
REQ-043 paddle_hit and ball_miss on the same cycle with score 0x05, lives 3 -> score 0x05, lives 2, miss_flash 1; after 63 ticks, ball_load pulse and ball_step 2.
REQ-044 Three misses with NUM_LIVES=3 -> game_over 1 after the final MISS timeout; start press -> lives 3, score 0x00, state SERVE.
REQ-045 Assert rst mid-MISS with the button held -> IDLE with reset values; no start_evt until the button is released and re-pressed.
